// File: rtl/img_capture_if.sv
// Signal bundle between the capture controller and its neighbours: pixel source,
// 1R1W image RAM and the DCT/quantiser input. The controller uses the master view.
interface img_capture_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              pix_valid;
  logic [10:0]       pix_x;
  logic [10:0]       pix_y;
  logic [7:0]        pix_luma;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic              buf_re;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;
  logic              mcu_valid;
  logic              mcu_ready;
  logic [7:0]        mcu_data;
  logic              mcu_first;
  logic              mcu_last;
  logic [9:0]        blk_idx;
  logic              busy;
  logic              done;

  modport master (
    input  start, pix_valid, pix_x, pix_y, pix_luma, buf_rdata, mcu_ready,
    output buf_we, buf_waddr, buf_wdata, buf_re, buf_raddr,
           mcu_valid, mcu_data, mcu_first, mcu_last, blk_idx, busy, done
  );

  modport slave (
    output start, pix_valid, pix_x, pix_y, pix_luma, buf_rdata, mcu_ready,
    input  buf_we, buf_waddr, buf_wdata, buf_re, buf_raddr,
           mcu_valid, mcu_data, mcu_first, mcu_last, blk_idx, busy, done
  );
endinterface

// File: rtl/img_capture_ctrl.sv
// Frame-buffer sequencer: captures a centred luma window into the image RAM, then
// streams it back as 8x8 MCUs with a credit-limited read pipeline and skid queue.
module img_capture_ctrl #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int X0     = 208,
  parameter int Y0     = 128,
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  img_capture_if.master io
);
  localparam int NBX  = IMG_W / 8;
  localparam int NBY  = IMG_H / 8;
  localparam int NBLK = NBX * NBY;
  localparam int BW   = $clog2(((NBX > NBY) ? NBX : NBY) + 1);
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + IMG_W - 1);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + IMG_H - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, READ, DONE} state_t;
  typedef struct packed {logic first; logic last; logic [9:0] blk;} meta_t;
  typedef struct packed {meta_t m; logic [7:0] data;} beat_t;

  function automatic logic [ADDR_W-1:0] wr_addr(input logic [10:0] x, input logic [10:0] y);
    return ADDR_W'(IMG_W * (int'(y) - Y0) + (int'(x) - X0));
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [BW-1:0] bx, input logic [BW-1:0] by,
                                                input logic [2:0] r, input logic [2:0] c);
    return ADDR_W'((8 * int'(by) + int'(r)) * IMG_W + 8 * int'(bx) + int'(c));
  endfunction

  state_t          state;
  logic            wr_last_p0;
  logic [2:0]      rd_c, rd_r;
  logic [BW-1:0]   rd_bx, rd_by;
  logic [9:0]      rd_blk;
  logic            rd_all;
  meta_t           meta_p0, meta_p1;
  logic            vld_p1;
  beat_t           q [0:2];
  logic [1:0]      q_cnt;

  logic       in_win, sof, pop, last_xfer, end_cap, issue;
  logic [2:0] credit;
  logic [1:0] wr_slot;

  // Credit counts every beat already queued or still in the RAM read pipeline,
  // so a stall can never overflow the three queue slots.
  always_comb begin
    in_win    = (io.pix_x >= X_LO) && (io.pix_x <= X_HI) && (io.pix_y >= Y_LO) && (io.pix_y <= Y_HI);
    sof       = io.pix_valid && (io.pix_x == 11'd0) && (io.pix_y == 11'd0);
    pop       = (q_cnt != 2'd0) && io.mcu_ready;
    last_xfer = pop && q[0].m.last && (q[0].m.blk == 10'(NBLK - 1));
    end_cap   = (state == CAPTURE) && io.buf_we && wr_last_p0;
    credit    = 3'(q_cnt) + 3'(io.buf_re) + 3'(vld_p1);
    issue     = ((state == READ) || end_cap) && !rd_all && ((credit - 3'(pop)) <= 3'd2);
    wr_slot   = q_cnt - 2'(pop);
  end

  // Stage p0: control FSM, registered RAM write and RAM read issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      io.busy      <= 1'b0;
      io.done      <= 1'b0;
      io.buf_we    <= 1'b0;
      io.buf_waddr <= '0;
      io.buf_wdata <= '0;
      wr_last_p0   <= 1'b0;
      io.buf_re    <= 1'b0;
      io.buf_raddr <= '0;
      meta_p0      <= '0;
      rd_c         <= '0;
      rd_r         <= '0;
      rd_bx        <= '0;
      rd_by        <= '0;
      rd_blk       <= '0;
      rd_all       <= 1'b0;
    end else begin
      io.done    <= 1'b0;
      io.buf_we  <= 1'b0;
      wr_last_p0 <= 1'b0;
      if (io.pix_valid && in_win &&
          (((state == WAIT_SOF) && sof) || ((state == CAPTURE) && !end_cap))) begin
        io.buf_we    <= 1'b1;
        io.buf_waddr <= wr_addr(io.pix_x, io.pix_y);
        io.buf_wdata <= io.pix_luma;
        wr_last_p0   <= (io.pix_x == X_HI) && (io.pix_y == Y_HI);
      end

      io.buf_re <= issue;
      if (issue) begin
        io.buf_raddr <= rd_addr(rd_bx, rd_by, rd_r, rd_c);
        meta_p0      <= '{first: (rd_r == 3'd0) && (rd_c == 3'd0),
                          last:  (rd_r == 3'd7) && (rd_c == 3'd7),
                          blk:   rd_blk};
        rd_c <= rd_c + 3'd1;
        if (rd_c == 3'd7) begin
          rd_r <= rd_r + 3'd1;
          if (rd_r == 3'd7) begin
            rd_blk <= rd_blk + 10'd1;
            if (rd_bx == BW'(NBX - 1)) begin
              rd_bx <= '0;
              rd_by <= rd_by + BW'(1);
              if (rd_by == BW'(NBY - 1)) rd_all <= 1'b1;
            end else begin
              rd_bx <= rd_bx + BW'(1);
            end
          end
        end
      end

      case (state)
        IDLE: if (io.start) begin
          state   <= WAIT_SOF;
          io.busy <= 1'b1;
          rd_c    <= '0;
          rd_r    <= '0;
          rd_bx   <= '0;
          rd_by   <= '0;
          rd_blk  <= '0;
          rd_all  <= 1'b0;
        end
        WAIT_SOF: if (sof) state <= CAPTURE;
        CAPTURE:  if (end_cap) state <= READ;
        READ: if (last_xfer) begin
          state   <= DONE;
          io.done <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          io.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: RAM data lands, joins its metadata in the output/skid queue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      meta_p1 <= '0;
      q_cnt   <= '0;
      for (int i = 0; i < 3; i++) q[i] <= '0;
    end else begin
      vld_p1  <= io.buf_re;
      meta_p1 <= meta_p0;
      if (pop) begin
        q[0] <= q[1];
        q[1] <= q[2];
      end
      for (int i = 0; i < 3; i++) begin
        if (vld_p1 && (wr_slot == 2'(i))) q[i] <= '{m: meta_p1, data: io.buf_rdata};
      end
      q_cnt <= q_cnt + 2'(vld_p1) - 2'(pop);
    end
  end

  assign io.mcu_valid = (q_cnt != 2'd0);
  assign io.mcu_data  = q[0].data;
  assign io.mcu_first = q[0].m.first;
  assign io.mcu_last  = q[0].m.last;
  assign io.blk_idx   = q[0].m.blk;
endmodule

// File: tb/tb_img_capture_ctrl.sv
// Directed bench for img_capture_ctrl on a reduced 32x24 window: write and MCU
// scoreboards, backpressure hold, start/pixel interference and mid-read reset.
module tb_img_capture_ctrl;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 24;
  localparam int X0     = 208;
  localparam int Y0     = 128;
  localparam int ADDR_W = 16;
  localparam int N      = IMG_W * IMG_H;
  localparam int NBX    = IMG_W / 8;
  localparam int NBLK   = N / 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  img_capture_if #(.ADDR_W(ADDR_W)) bus ();

  img_capture_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Image RAM model; read data is scrambled on cycles without a read.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
    bus.buf_rdata <= bus.buf_re ? mem[bus.buf_raddr] : 8'($urandom);
  end

  typedef struct packed {logic [ADDR_W-1:0] a; logic [7:0] d;} wr_t;
  wr_t         wr_q [$];
  logic [19:0] mcu_q [$];
  logic [7:0]  img [0:N-1];

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;
  int n_wr, n_rd, n_beat, n_last, n_done, n_unexp_wr, n_unexp_beat;
  int re_rise, val_rise, last_beat;
  bit re_seen, val_seen, stall_prev;
  logic [19:0] hold_vec;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return 96'({bus.busy, bus.done, bus.buf_we, bus.buf_re, bus.mcu_valid, bus.mcu_first,
                bus.mcu_last, bus.mcu_data, bus.blk_idx, bus.buf_waddr, bus.buf_raddr,
                bus.buf_wdata});
  endfunction

  task automatic frame_begin();
    n_wr = 0; n_rd = 0; n_beat = 0; n_last = 0; n_done = 0;
    n_unexp_wr = 0; n_unexp_beat = 0;
    re_seen = 0; val_seen = 0; stall_prev = 0;
    re_rise = 0; val_rise = 0; last_beat = 0;
  endtask

  // Observes outputs mid-cycle, scoreboards writes and MCU beats.
  task automatic monitor();
    wr_t w;
    logic [19:0] vec;
    if (!reset_n) return;
    if (bus.buf_we) begin
      n_wr++;
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("wr_addr_data", 96'({bus.buf_waddr, bus.buf_wdata}), 96'(w));
      end else n_unexp_wr++;
    end
    if (bus.buf_re) begin
      n_rd++;
      if (!re_seen) begin
        re_seen = 1; re_rise = cyc;
        check("first_raddr", 96'(bus.buf_raddr), 96'd0);
      end
    end
    vec = {bus.mcu_first, bus.mcu_last, bus.blk_idx, bus.mcu_data};
    if (bus.mcu_valid) begin
      if (!val_seen) begin val_seen = 1; val_rise = cyc; end
      if (stall_prev) check("stall_hold", 96'(vec), 96'(hold_vec));
      if (bus.mcu_ready) begin
        n_beat++;
        last_beat = cyc;
        if (bus.mcu_last) n_last++;
        if (mcu_q.size() != 0) check("mcu_beat", 96'(vec), 96'(mcu_q.pop_front()));
        else n_unexp_beat++;
      end
      stall_prev = !bus.mcu_ready;
      hold_vec = vec;
    end else stall_prev = 0;
    if (bus.done) n_done++;
  endtask

  // One clock: monitor mid-cycle, then return just after the next edge with
  // one-shot inputs dropped and the ready policy applied.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.mcu_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  endtask

  task automatic set_pix(input int x, input int y, input logic [7:0] l);
    bus.pix_valid = 1'b1;
    bus.pix_x = 11'(x);
    bus.pix_y = 11'(y);
    bus.pix_luma = l;
  endtask

  task automatic capture(input int seed, input bit poke);
    bit fin = 0;
    logic [7:0] l;
    frame_begin();
    bus.start = 1'b1;
    step();
    check("busy_after_start", 96'(bus.busy), 96'd1);
    for (int i = 0; i < 3; i++) begin
      set_pix(X0 + i, Y0 + i, 8'hc3);
      step();
    end
    set_pix(0, 0, 8'h5a);
    step();
    for (int y = Y0 - 1; y < Y0 + IMG_H && !fin; y++) begin
      for (int x = X0 - 2; x < X0 + IMG_W + 2 && !fin; x++) begin
        l = 8'((x ^ y) + seed);
        set_pix(x, y, l);
        if (x >= X0 && x < X0 + IMG_W && y >= Y0) begin
          img[(y - Y0) * IMG_W + (x - X0)] = l;
          wr_q.push_back('{a: ADDR_W'((y - Y0) * IMG_W + (x - X0)), d: l});
        end
        if (poke && y == Y0 + 2 && x == X0 + 3) bus.start = 1'b1;
        fin = (x == X0 + IMG_W - 1) && (y == Y0 + IMG_H - 1);
        step();
        if (!fin && ((x + y) % 13 == 0)) step();
      end
    end
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          int bx = b % NBX;
          int by = b / NBX;
          mcu_q.push_back({(r == 0) && (c == 0), (r == 7) && (c == 7), 10'(b),
                           img[(8 * by + r) * IMG_W + 8 * bx + c]});
        end
  endtask

  task automatic finish_frame(input int budget, input bit poke, input bit timing);
    bit got_done = 0;
    for (int k = 0; k < budget && !got_done; k++) begin
      if (poke && k == 40) bus.start = 1'b1;
      if (poke && k >= 50 && k < 54) set_pix(X0 + k - 50, Y0, 8'hee);
      step();
      got_done = (n_done != 0);
    end
    check("done_seen", 96'(got_done), 96'd1);
    check("busy_after_done", 96'(bus.busy), 96'd0);
    repeat (4) step();
    check("done_pulses", 96'(n_done), 96'd1);
    check("write_count", 96'(n_wr), 96'(N));
    check("read_count", 96'(n_rd), 96'(N));
    check("beat_count", 96'(n_beat), 96'(N));
    check("last_count", 96'(n_last), 96'(NBLK));
    check("unexp_writes", 96'(n_unexp_wr), 96'd0);
    check("unexp_beats", 96'(n_unexp_beat), 96'd0);
    check("beats_left", 96'(mcu_q.size()), 96'd0);
    if (timing) begin
      check("read_latency", 96'(val_rise - re_rise), 96'd2);
      check("no_bubbles", 96'(last_beat - val_rise), 96'(N - 1));
    end
  endtask

  initial begin
    bit found = 0;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    bus.pix_luma = '0;
    bus.mcu_ready = 1'b1;
    frame_begin();
    repeat (3) step();
    check("reset_outputs", outs(), 96'd0);
    reset_n = 1'b1;
    step();
    check("idle_outputs", outs(), 96'd0);

    // Frame 1: ready held high, start and pixels poked while busy
    ready_mode = 1;
    capture(0, 1);
    finish_frame(3000, 1, 1);

    // Frame 2: random backpressure, new image
    ready_mode = 2;
    capture(37, 0);
    finish_frame(20000, 0, 0);

    // Frame 3: reset once block 5 is on the output
    ready_mode = 1;
    capture(91, 0);
    for (int k = 0; k < 3000 && !found; k++) begin
      step();
      found = bus.mcu_valid && (bus.blk_idx == 10'd5);
    end
    check("reached_blk5", 96'(found), 96'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort_outputs", outs(), 96'd0);
    mcu_q.delete();
    wr_q.delete();
    frame_begin();
    repeat (6) step();
    check("quiet_after_abort", outs(), 96'd0);
    check("no_access_after_abort", 96'(n_wr + n_rd), 96'd0);

    // Frame 4: fresh capture after the abort
    capture(150, 0);
    finish_frame(3000, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
